jt12_shx: RTL and testbench
===========================

# jt12_shx

Parametrised successor to the fixed-length bit-slice delay line used across the FM pipeline (operator, envelope and phase channel rotation). It keeps the `clk_en`-gated shift behaviour and adds:
- asynchronous active-low reset to a parameter value;
- a runtime-selectable delay length;
- a random-access tap;
- a serial save-state dump/restore engine driven by a small FSM.

Its save-state interface is narrow and streaming, replacing the wide parallel bus.

## Interface
- `width`, 5: bits per element.
- `stages`, 24: maximum depth; must be ≥ 2.
- `init`, 0: `width`-bit reset value of every element.
- `LW` (localparam) = `$clog2(stages+1)`: width of `len`.
- `TW` (localparam) = `$clog2(stages)`: width of `tap_sel`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clk_en` in 1: shift enable, sampled on `posedge clk`.
- `din` in `width`: new element.
- `len` in `LW`: effective delay, range 1..`stages`.
- `drop` out `width`: element at position `len`-1.
- `tap_sel` in `TW`: tap position, 0 = newest.
- `tap` out `width`: element at position `tap_sel`.
- `ss_dump` in 1: start-dump request, level-sampled.
- `ss_load` in 1: start-restore request, level-sampled.
- `ss_busy` out 1: FSM not IDLE.
- `ss_dout` out `width`: dump word.
- `ss_dvalid` out 1: `ss_dout` valid.
- `ss_din` in `width`: restore word.
- `ss_din_valid` in 1: `ss_din` valid.

## Operation
Storage is `stages` elements, `e[0]` (newest) … `e[stages-1]` (oldest).

- **FSM states:** IDLE, DUMP, LOAD. A counter `cnt` (`LW` bits) counts words.
- **IDLE:**
  - `clk_en`=1: `e[0]`←`din`, `e[k]`←`e[k-1]`.
  - `clk_en`=0: hold.
  - `ss_dump`=1: go to DUMP, `cnt`←0.
  - else `ss_load`=1: go to LOAD, `cnt`←0.
  - Both requests high in the same cycle: DUMP wins, load is ignored.
  - A request is acted on in the same cycle as any `clk_en` shift; the shift still happens.
- **DUMP:**
  - Every cycle, rotate: `e[0]`←`e[stages-1]`, `e[k]`←`e[k-1]`; `cnt`++.
  - At `cnt`=`stages`-1, return to IDLE.
  - After exactly `stages` rotations the contents are back in their original positions (non-destructive).
- **LOAD:**
  - On each cycle with `ss_din_valid`=1: `e[0]`←`ss_din`, shift; `cnt`++.
  - On the accept that makes `stages` words, return to IDLE.
  - Cycles with `ss_din_valid`=0 hold state.
  - The first word restored ends up in `e[stages-1]`, matching dump order (oldest first), so dump→load is a lossless round trip.
- **In DUMP/LOAD:** `clk_en` is ignored (samples are dropped; the system must hold the engine during save-state). `ss_dump` and `ss_load` are ignored.
- **`drop`:** combinational mux of `e[len_c-1]`, where `len_c` = 1 if `len`=0, `stages` if `len`>`stages`, else `len`. A `len` change takes effect on `drop` immediately; contents are unaffected.
- **`tap`:** combinational `e[tap_sel]`. If `tap_sel` ≥ `stages`, `tap` = `e[stages-1]`.
- **`ss_dout`:** combinational `e[stages-1]`. `ss_dvalid` = (state==DUMP).

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - all `e`=`init`, state IDLE, `cnt`=0;
  - hence `drop`=`tap`=`ss_dout`=`init`, `ss_busy`=0, `ss_dvalid`=0.
- **Reset mid-DUMP/LOAD:** aborts immediately to IDLE with the contents cleared to `init`. A partial load is never kept.
- **Delay:** with constant `len`=L, `drop` after the n-th enabled edge equals `din` sampled at the (n-L+1)-th enabled edge, i.e. L `clk_en` ticks of delay. Non-enabled cycles do not count.
- **Dump:**
  - Request sampled at edge T; `ss_busy` and `ss_dvalid` go high after T.
  - Words appear on `ss_dout` in cycles T+1..T+`stages`, oldest first, one per cycle, with no backpressure.
  - `ss_busy` falls after edge T+`stages`. A new request may be sampled at that same edge's following cycle.
- **Load:** `ss_busy` is high from after the request edge until after the edge accepting word `stages`. Throughput is at most 1 word per cycle.
- **Paths:** `drop`, `tap` and `ss_dout` have register-to-output mux paths only. No input-to-output combinational path except `len`/`tap_sel` → mux select.

## Test plan
- **Reset:** `width`=5, `stages`=24, `init`=5'h1F; assert `rst_n`=0 asynchronously mid-cycle → `drop`=`tap`=5'h1F and `ss_busy`=0 before the next edge.
- **Delay and length:** `len`=24, `clk_en`=1, `din`=1,2,3… → `drop` shows 1 after the 24th edge. Switch to `len`=3 → `drop` = `din` from 3 ticks earlier on the next cycle. Hold `clk_en`=0 for 5 cycles → `drop` frozen. `len`=0 behaves as 1.
- **Tap:** fill 0..23 → `tap_sel`=0 gives 23, 23 gives 0, 31 gives 0 (clamped).
- **Dump:** load 0..23, pulse `ss_dump` → `ss_dvalid` high exactly 24 cycles, `ss_dout`=0,1,…,23. `clk_en` pulses during dump are ignored. Afterwards `tap` readings are identical to before.
- **Load round trip:** dump, reset, then `ss_load` with the captured words, `ss_din_valid` toggled 1/0 → `ss_busy` spans 48 cycles, final contents equal the pre-dump contents. Asserting `ss_load` during the load changes nothing.
- **Conflicts and abort:** `ss_dump`+`ss_load` in the same cycle → DUMP only. `rst_n` low at word 10 of a load → all elements `init`, state IDLE.

Source files
------------

// File: rtl/jt12_shx.sv
// Clock-enabled bit-slice delay line with runtime length, random-access tap and a
// serial save-state engine that dumps (rotates) or restores the contents one word per cycle.
module jt12_shx #(
  parameter int               width  = 5,
  parameter int               stages = 24,
  parameter logic [width-1:0] init   = '0,
  localparam int              LW     = $clog2(stages+1),
  localparam int              TW     = $clog2(stages)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [width-1:0] din,
  input  logic [LW-1:0]    len,
  output logic [width-1:0] drop,
  input  logic [TW-1:0]    tap_sel,
  output logic [width-1:0] tap,
  input  logic             ss_dump,
  input  logic             ss_load,
  output logic             ss_busy,
  output logic [width-1:0] ss_dout,
  output logic             ss_dvalid,
  input  logic [width-1:0] ss_din,
  input  logic             ss_din_valid
);

  // Save-state handshakes: ss_dout is valid on every cycle ss_dvalid is high and has no
  // ready (the consumer must take one word per cycle). ss_din is consumed on every LOAD
  // cycle where ss_din_valid is high; the engine is always ready while loading.
  typedef enum logic [1:0] {IDLE, DUMP, LOAD} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] e_q [stages];
  logic             shift_en;
  logic [width-1:0] shift_in;
  logic [LW-1:0]    len_c;
  logic [TW-1:0]    drop_idx, tap_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    shift_in = din;
    case (state_q)
      IDLE: begin
        shift_en = clk_en;
        if (ss_dump) begin
          state_d = DUMP;
          cnt_d   = '0;
        end else if (ss_load) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        // Rotating the oldest word back to the front makes a full dump non-destructive.
        shift_en = 1'b1;
        shift_in = e_q[stages-1];
        cnt_d    = cnt_q + LW'(1);
        if (cnt_q == LW'(stages-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ss_din_valid) begin
          shift_en = 1'b1;
          shift_in = ss_din;
          cnt_d    = cnt_q + LW'(1);
          if (cnt_q == LW'(stages-1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < stages; i++) e_q[i] <= init;
    end else if (shift_en) begin
      e_q[0] <= shift_in;
      for (int k = 1; k < stages; k++) e_q[k] <= e_q[k-1];
    end
  end

  // Out-of-range selects are clamped so the muxes never index past the storage.
  always_comb begin
    if (len == '0)                len_c = LW'(1);
    else if (int'(len) > stages)  len_c = LW'(stages);
    else                          len_c = len;
    drop_idx = TW'(len_c - LW'(1));
    if (int'(tap_sel) >= stages)  tap_idx = TW'(stages-1);
    else                          tap_idx = tap_sel;
  end

  assign drop      = e_q[drop_idx];
  assign tap       = e_q[tap_idx];
  assign ss_dout   = e_q[stages-1];
  assign ss_busy   = (state_q != IDLE);
  assign ss_dvalid = (state_q == DUMP);

endmodule

// File: tb/tb_jt12_shx.sv
// Bench for jt12_shx: queue-based reference model of the delay line, randomized and
// directed scenarios for delay, tap, dump, load round trip, conflicts and reset abort.
module tb_jt12_shx;

  localparam int         W    = 5;
  localparam int         S    = 24;
  localparam logic [W-1:0] INIT = 5'h1F;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b0;
  logic [W-1:0] din = '0;
  logic [4:0]   len = 5'd24;
  logic [W-1:0] drop;
  logic [4:0]   tap_sel = '0;
  logic [W-1:0] tap;
  logic         ss_dump = 1'b0;
  logic         ss_load = 1'b0;
  logic         ss_busy;
  logic [W-1:0] ss_dout;
  logic         ss_dvalid;
  logic [W-1:0] ss_din = '0;
  logic         ss_din_valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference contents: index 0 is the newest element, index S-1 the oldest.
  logic [W-1:0] mdl[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] snap[S];
  logic [W-1:0] captured[S];

  jt12_shx #(.width(W), .stages(S), .init(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .din(din), .len(len), .drop(drop),
    .tap_sel(tap_sel), .tap(tap), .ss_dump(ss_dump), .ss_load(ss_load), .ss_busy(ss_busy),
    .ss_dout(ss_dout), .ss_dvalid(ss_dvalid), .ss_din(ss_din), .ss_din_valid(ss_din_valid)
  );

  always #50 clk = ~clk;

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > S) return S;
    return l;
  endfunction

  function automatic int eff_tap(input int t);
    return (t >= S) ? S - 1 : t;
  endfunction

  task automatic model_reset();
    mdl.delete();
    for (int i = 0; i < S; i++) mdl.push_back(INIT);
  endtask

  task automatic model_push(input logic [W-1:0] v);
    mdl.push_front(v);
    void'(mdl.pop_back());
  endtask

  task automatic drive_idle();
    clk_en = 1'b0;
    ss_dump = 1'b0;
    ss_load = 1'b0;
    ss_din_valid = 1'b0;
  endtask

  // One clock: inputs applied in the low phase, outputs observable at the next negedge.
  task automatic step_shift(input logic en, input logic [W-1:0] d);
    clk_en = en;
    din = d;
    @(posedge clk);
    if (en) model_push(d);
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) step_shift(1'b1, W'($urandom_range(0, 30)));
    @(posedge clk);
    #20;
    rst_n = 1'b0;
    model_reset();
    #1;
    tap_sel = 5'd3;
    #1;
    vectors++;
    if (drop !== INIT) begin miscompares++; $display("FAIL reset_drop got %h want %h", drop, INIT); end
    vectors++;
    if (tap !== INIT) begin miscompares++; $display("FAIL reset_tap got %h want %h", tap, INIT); end
    vectors++;
    if (ss_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", ss_busy); end
    vectors++;
    if (ss_dvalid !== 1'b0 || ss_dout !== INIT) begin
      miscompares++; $display("FAIL reset_dout got %b/%h want 0/%h", ss_dvalid, ss_dout, INIT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_delay();
    logic [W-1:0] held;
    len = 5'd24;
    for (int i = 1; i <= 30; i++) begin
      step_shift(1'b1, W'(i));
      vectors++;
      if (drop !== mdl[eff_len(int'(len)) - 1]) begin
        miscompares++; $display("FAIL delay24 step %0d got %h want %h", i, drop, mdl[eff_len(int'(len)) - 1]);
      end
      if (i == 24) begin
        vectors++;
        if (drop !== 5'd1) begin miscompares++; $display("FAIL delay24_first got %h want 01", drop); end
      end
    end
    len = 5'd3;
    #1;
    vectors++;
    if (drop !== 5'd28) begin miscompares++; $display("FAIL len3 got %h want 1c", drop); end
    held = drop;
    for (int i = 0; i < 5; i++) begin
      step_shift(1'b0, W'($urandom_range(0, 31)));
      vectors++;
      if (drop !== held) begin miscompares++; $display("FAIL hold cycle %0d got %h want %h", i, drop, held); end
    end
    len = 5'd0;
    #1;
    vectors++;
    if (drop !== mdl[0]) begin miscompares++; $display("FAIL len0 got %h want %h", drop, mdl[0]); end
    len = 5'd31;
    #1;
    vectors++;
    if (drop !== mdl[S-1]) begin miscompares++; $display("FAIL len31 got %h want %h", drop, mdl[S-1]); end
    len = 5'd24;
  endtask

  task automatic test_tap();
    int sel_tab[3] = '{0, 23, 31};
    int exp_tab[3] = '{23, 0, 0};
    for (int i = 0; i < S; i++) step_shift(1'b1, W'(i));
    for (int i = 0; i < 3; i++) begin
      tap_sel = 5'(sel_tab[i]);
      #1;
      vectors++;
      if (tap !== W'(exp_tab[i])) begin
        miscompares++; $display("FAIL tap sel %0d got %h want %h", sel_tab[i], tap, W'(exp_tab[i]));
      end
    end
    for (int i = 0; i < 8; i++) begin
      tap_sel = 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (tap !== mdl[eff_tap(int'(tap_sel))]) begin
        miscompares++; $display("FAIL tap_rand sel %0d got %h want %h", tap_sel, tap, mdl[eff_tap(int'(tap_sel))]);
      end
    end
  endtask

  task automatic test_dump();
    for (int k = 0; k < S; k++) snap[k] = mdl[k];
    exp_q.delete();
    for (int k = S - 1; k >= 0; k--) exp_q.push_back(mdl[k]);
    ss_dump = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ss_dump = 1'b0;
    for (int w = 0; w < S; w++) begin
      logic [W-1:0] want;
      want = exp_q.pop_front();
      captured[w] = ss_dout;
      vectors++;
      if (ss_dvalid !== 1'b1 || ss_busy !== 1'b1 || ss_dout !== want) begin
        miscompares++; $display("FAIL dump word %0d got %b/%b/%h want 1/1/%h", w, ss_dvalid, ss_busy, ss_dout, want);
      end
      clk_en = 1'($urandom_range(0, 1));
      din = W'($urandom_range(0, 31));
      ss_load = 1'($urandom_range(0, 1));
      ss_dump = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    drive_idle();
    vectors++;
    if (ss_dvalid !== 1'b0 || ss_busy !== 1'b0) begin
      miscompares++; $display("FAIL dump_end got %b/%b want 0/0", ss_dvalid, ss_busy);
    end
    for (int t = 0; t < S; t++) begin
      tap_sel = 5'(t);
      #1;
      vectors++;
      if (tap !== snap[t]) begin miscompares++; $display("FAIL dump_intact e%0d got %h want %h", t, tap, snap[t]); end
    end
  endtask

  task automatic test_load_roundtrip();
    #10 rst_n = 1'b0;
    model_reset();
    #10 rst_n = 1'b1;
    len = 5'd24;
    #1;
    vectors++;
    if (drop !== INIT) begin miscompares++; $display("FAIL preload_clear got %h want %h", drop, INIT); end
    ss_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ss_load = 1'b0;
    for (int c = 0; c < 2 * S; c++) begin
      vectors++;
      if (ss_busy !== 1'b1 || ss_dvalid !== 1'b0) begin
        miscompares++; $display("FAIL load_busy cycle %0d got %b/%b want 1/0", c, ss_busy, ss_dvalid);
      end
      ss_din_valid = c[0];
      ss_din = c[0] ? captured[c / 2] : W'($urandom_range(0, 31));
      ss_load = 1'($urandom_range(0, 1));
      ss_dump = 1'($urandom_range(0, 1));
      clk_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    drive_idle();
    vectors++;
    if (ss_busy !== 1'b0) begin miscompares++; $display("FAIL load_end busy got %b want 0", ss_busy); end
    for (int t = 0; t < S; t++) begin
      tap_sel = 5'(t);
      #1;
      vectors++;
      if (tap !== snap[t]) begin miscompares++; $display("FAIL roundtrip e%0d got %h want %h", t, tap, snap[t]); end
    end
    mdl.delete();
    for (int k = 0; k < S; k++) mdl.push_back(snap[k]);
  endtask

  task automatic test_conflict_abort();
    for (int i = 0; i < S; i++) step_shift(1'b1, W'($urandom_range(0, 31)));
    exp_q.delete();
    for (int k = S - 1; k >= 0; k--) exp_q.push_back(mdl[k]);
    ss_dump = 1'b1;
    ss_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    for (int w = 0; w < S; w++) begin
      logic [W-1:0] want;
      want = exp_q.pop_front();
      vectors++;
      if (ss_dvalid !== 1'b1 || ss_dout !== want) begin
        miscompares++; $display("FAIL conflict word %0d got %b/%h want 1/%h", w, ss_dvalid, ss_dout, want);
      end
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (ss_busy !== 1'b0) begin miscompares++; $display("FAIL conflict_end busy got %b want 0", ss_busy); end
    ss_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ss_load = 1'b0;
    for (int w = 0; w < 10; w++) begin
      ss_din_valid = 1'b1;
      ss_din = W'($urandom_range(0, 30));
      @(posedge clk);
      @(negedge clk);
    end
    ss_din_valid = 1'b0;
    #10 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (ss_busy !== 1'b0 || ss_dvalid !== 1'b0 || drop !== INIT) begin
      miscompares++; $display("FAIL abort got %b/%b/%h want 0/0/%h", ss_busy, ss_dvalid, drop, INIT);
    end
    for (int t = 0; t < S; t++) begin
      tap_sel = 5'(t);
      #1;
      vectors++;
      if (tap !== INIT) begin miscompares++; $display("FAIL abort_clear e%0d got %h want %h", t, tap, INIT); end
    end
    #5 rst_n = 1'b1;
    ss_din_valid = 1'b1;
    ss_din = 5'h07;
    @(posedge clk);
    @(negedge clk);
    ss_din_valid = 1'b0;
    tap_sel = 5'd0;
    #1;
    vectors++;
    if (ss_busy !== 1'b0 || tap !== mdl[0]) begin
      miscompares++; $display("FAIL abort_idle got %b/%h want 0/%h", ss_busy, tap, mdl[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      clk_en = 1'($urandom_range(0, 1));
      din = W'($urandom_range(0, 31));
      len = 5'($urandom_range(0, 31));
      tap_sel = 5'($urandom_range(0, 31));
      @(posedge clk);
      if (clk_en) model_push(din);
      @(negedge clk);
      vectors++;
      if (drop !== mdl[eff_len(int'(len)) - 1] || tap !== mdl[eff_tap(int'(tap_sel))] || ss_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random n %0d len %0d sel %0d got %h/%h/%b want %h/%h/0", n, len, tap_sel,
                 drop, tap, ss_busy, mdl[eff_len(int'(len)) - 1], mdl[eff_tap(int'(tap_sel))]);
      end
    end
    clk_en = 1'b0;
  endtask

  initial begin
    model_reset();
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_delay();
    test_tap();
    test_dump();
    test_load_roundtrip();
    test_conflict_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
